// File: rtl/ex_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage. It owns the HI/LO
// registers and holds the front of the pipe while an operation is in flight.
`timescale 1ns/1ps
module ex_muldiv_ctrl #(
    parameter int XLEN = 32,
    parameter int CNTW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StartE,
    input  logic [1:0]      MulDivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            MthiE,
    input  logic            MtloE,
    input  logic            FlushE,
    output logic [XLEN-1:0] HiOut,
    output logic [XLEN-1:0] LoOut,
    output logic            StallMD,
    output logic            BusyMD,
    output logic            DoneMD
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(XLEN - 1);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] src_a_q, src_a_d;
    logic            is_div_q, is_div_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            div0_q, div0_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            start_ok;
    logic            op_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_trial;
    logic            div_fits;
    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign start_ok  = (state_q == S_IDLE) && StartE && !FlushE;
    assign op_signed = ~MulDivOpE[0];
    assign a_neg     = op_signed & SrcAE[XLEN-1];
    assign b_neg     = op_signed & SrcBE[XLEN-1];
    assign a_mag     = a_neg ? (~SrcAE + 1'b1) : SrcAE;
    assign b_mag     = b_neg ? (~SrcBE + 1'b1) : SrcBE;

    // Multiply: {acc_hi, acc_lo} starts as {0, multiplier} and shifts right,
    // adding the multiplicand into the upper half whenever the LSB is set.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out
    // of the top and quotient bits in at the bottom.
    assign div_trial = {acc_hi_q, acc_lo_q[XLEN-1]} - {1'b0, opnd_q};
    assign div_fits  = ~div_trial[XLEN];

    assign prod_raw = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_res_q ? (~prod_raw + 1'b1) : prod_raw;
    assign quo_fix  = neg_res_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
    assign rem_fix  = neg_rem_q ? (~acc_hi_q + 1'b1) : acc_hi_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        src_a_d   = src_a_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    is_div_d  = MulDivOpE[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = MulDivOpE[1] && (SrcBE == '0);
                    src_a_d   = SrcAE;
                    acc_hi_d  = '0;
                    if (MulDivOpE[1]) begin
                        acc_lo_d = a_mag;
                        opnd_d   = b_mag;
                    end else begin
                        acc_lo_d = b_mag;
                        opnd_d   = a_mag;
                    end
                end else if (!StartE) begin
                    if (MthiE) hi_d = SrcAE;
                    if (MtloE) lo_d = SrcAE;
                end
            end
            S_RUN: begin
                if (FlushE) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        if (div_fits) begin
                            acc_hi_d = div_trial[XLEN-1:0];
                            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_hi_d = {acc_hi_q[XLEN-2:0], acc_lo_q[XLEN-1]};
                            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_d = mul_sum[XLEN:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (FlushE) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*XLEN-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end else if (div0_q) begin
                        hi_d = src_a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: begin
                // DONE: the same instruction is still sitting in EX, so any
                // StartE seen here belongs to it and must not relaunch.
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            src_a_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            src_a_q   <= src_a_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The launch cycle must stall before the FSM has left IDLE.
    assign StallMD = start_ok | busy_q;
    assign BusyMD  = busy_q;
    assign DoneMD  = done_q;
    assign HiOut   = hi_q;
    assign LoOut   = lo_q;

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer beside the EX-stage ALU.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and owns the architectural HI/LO registers.
- Raises a stall request to the hazard unit so F/D/E hold while an operation is in flight.
- Services MTHI/MTLO writes and drives HI/LO for MFHI/MFLO.

Parameters:
- XLEN, 32, operand/result width.
- CNTW, 5, iteration counter width (clog2 XLEN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- StartE  in  1  mul/div instruction present in EX.
- MulDivOpE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcAE  in  XLEN  forwarded operand A (multiplicand/dividend).
- SrcBE  in  XLEN  forwarded operand B (multiplier/divisor).
- MthiE  in  1  write HI from SrcAE.
- MtloE  in  1  write LO from SrcAE.
- FlushE  in  1  squash EX-stage instruction.
- HiOut  out  XLEN  current HI.
- LoOut  out  XLEN  current LO.
- StallMD  out  1  stall request to hazard unit.
- BusyMD  out  1  state is RUN or FIX.
- DoneMD  out  1  one-cycle pulse after HI/LO update.

Behaviour:
- Reset (async, rst_n=0): state IDLE, HI=LO=0, counter=0, StallMD=BusyMD=DoneMD=0.
- States:
  - IDLE: StartE=1 and FlushE=0 -> capture operands, signedness and op; go to RUN with count=0.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on operand magnitudes. count increments; at count==XLEN-1 go to FIX.
  - FIX: apply sign correction, write HI/LO at the closing edge, go to DONE.
  - DONE: DoneMD=1; StartE is ignored (the same instruction is still in EX); go to IDLE unconditionally.
- Latency: StartE high in cycle T (IDLE) -> RUN T+1..T+32 -> FIX T+33 -> HI/LO visible and DoneMD=1 in T+34.
- StallMD = (IDLE & StartE & ~FlushE) | RUN | FIX, i.e. high for 34 cycles (T..T+33), low in DONE so the instruction retires.
- Operand capture: operands are latched at the IDLE->RUN edge. Later changes on SrcAE/SrcBE are ignored.
- Multiply: 64-bit product, HI=upper 32 bits, LO=lower 32 bits. Signed ops negate the product iff operand signs differ.
- Divide: LO=quotient, HI=remainder.
  - Signed quotient is negated iff operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - -2^31 / -1 gives LO=0x80000000, HI=0 (no trap).
- Divide by zero (detected at start, applies to both signed and unsigned): full latency kept; LO=0xFFFFFFFF, HI=captured SrcAE.
- MTHI/MTLO: honoured only in IDLE with StartE=0; HI/LO update at the next edge. Ignored in RUN/FIX/DONE. If StartE and an Mt* are both high, StartE wins.
- FlushE:
  - In IDLE: blocks the start.
  - In RUN or FIX: abort to IDLE next edge, HI/LO unchanged, no DoneMD.
  - In DONE: no effect.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.
- HiOut/LoOut: register outputs, combinationally visible, no bypass of in-flight results.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> StallMD high exactly 34 cycles; DoneMD at T+34; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100. MTLO 0x1234 while idle -> LoOut=0x1234 next cycle.
- Precondition HI=0xAA, LO=0xBB; start MULTU, assert FlushE at RUN cycle 10 -> IDLE next cycle; HI=0xAA, LO=0xBB; no DoneMD.
- rst_n low during RUN -> immediately HI=LO=0, StallMD=0. StartE held high through DONE -> no second operation starts.
